// File: rtl/code_ram_mp_if.sv
// Request/grant/rvalid bundle for all requestor ports of code_ram_mp.
// Latency: none, wires only.
// Backpressure: requestors hold req until they see gnt.
interface code_ram_mp_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0]    req;
  logic [NUM_PORTS-1:0]    we;
  logic [4*NUM_PORTS-1:0]  be;
  logic [32*NUM_PORTS-1:0] addr;
  logic [32*NUM_PORTS-1:0] wdata;
  logic [NUM_PORTS-1:0]    gnt;
  logic [NUM_PORTS-1:0]    rvalid;
  logic [NUM_PORTS-1:0]    err;
  logic [31:0]             rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/code_ram_mp.sv
// Multi-port code/data RAM: arbitrates N req/gnt/rvalid ports onto one synchronous SRAM.
// Latency: gnt combinational in the request cycle; rvalid READ_LATENCY cycles after the grant edge.
// Backpressure: one grant per cycle; losing ports see gnt=0 and keep requesting, responses never stall.
module code_ram_mp #(
  parameter int          NUM_PORTS    = 2,
  parameter int          DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ARB_MODE     = 0,
  parameter int          READ_LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  code_ram_mp_if.slave bus
);

  localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          PW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 2;

  // arbitration
  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] last_q;
  logic [PW-1:0] last_d;
  int            rr_cand;
  logic [NUM_PORTS-1:0] gnt_d;

  // selected request
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] off;
  logic        in_range;
  logic        ram_en;
  logic [AW-1:0] widx;

  // storage
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] ram_rdata_q;

  // response pipeline
  logic          s1_vld_q;
  logic [PW-1:0] s1_idx_q;
  logic          s1_we_q;
  logic          s1_err_q;
  logic [31:0]   s1_rdata;
  logic          out_vld;
  logic [PW-1:0] out_idx;
  logic          out_err;
  logic [31:0]   out_rdata;
  logic [NUM_PORTS-1:0] rvalid_d;
  logic [NUM_PORTS-1:0] err_d;
  logic [31:0]          rdata_d;

  // Pick the winning port; nothing is granted while rst is high, which also blocks writes.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_cand = 0;
    if (!rst) begin
      if (ARB_MODE == 1) begin
        // Search starts just after the last winner so every port gets a turn.
        for (int k = 1; k <= NUM_PORTS; k++) begin
          rr_cand = int'(last_q) + k;
          if (rr_cand >= NUM_PORTS) rr_cand = rr_cand - NUM_PORTS;
          if (!gnt_vld && bus.req[rr_cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(rr_cand);
          end
        end
      end else begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
          if (bus.req[p]) begin
            gnt_vld = 1'b1;
            gnt_idx = PW'(p);
          end
        end
      end
    end
    last_d = gnt_vld ? gnt_idx : last_q;
  end

  // One-hot grant vector and mux of the winner's request fields.
  always_comb begin
    gnt_d     = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_vld && gnt_idx == PW'(p)) begin
        gnt_d[p]  = 1'b1;
        sel_we    = bus.we[p];
        sel_be    = bus.be[4*p +: 4];
        sel_addr  = bus.addr[32*p +: 32];
        sel_wdata = bus.wdata[32*p +: 32];
      end
    end
  end

  // Decode: unsigned wrap makes addresses below BASE_ADDR land far out of range.
  always_comb begin
    off      = sel_addr - BASE_ADDR;
    in_range = ({1'b0, off} < RANGE_BYTES);
    widx     = off[AW+1:2];
    ram_en   = gnt_vld && in_range;
  end

  // Round-robin pointer; only moves on cycles that grant something.
  always_ff @(posedge clk) begin
    if (rst) last_q <= PW'(NUM_PORTS - 1);
    else     last_q <= last_d;
  end

  // Single-ported SRAM: byte-masked write or word read; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_en && sel_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) mem_q[widx][8*b +: 8] <= sel_wdata[8*b +: 8];
      end
    end
    if (ram_en && !sel_we) ram_rdata_q <= mem_q[widx];
  end

  // First response stage travels alongside the SRAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
      s1_we_q  <= 1'b0;
      s1_err_q <= 1'b0;
    end else begin
      s1_vld_q <= gnt_vld;
      s1_idx_q <= gnt_idx;
      s1_we_q  <= sel_we;
      s1_err_q <= gnt_vld && !in_range;
    end
  end

  // Writes and errors return zero data; only in-range reads expose the SRAM word.
  assign s1_rdata = (s1_vld_q && !s1_we_q && !s1_err_q) ? ram_rdata_q : 32'h0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic          s2_vld_q;
      logic [PW-1:0] s2_idx_q;
      logic          s2_err_q;
      logic [31:0]   s2_rdata_q;

      // Second stage registers the already-masked read data.
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_vld_q   <= 1'b0;
          s2_idx_q   <= '0;
          s2_err_q   <= 1'b0;
          s2_rdata_q <= '0;
        end else begin
          s2_vld_q   <= s1_vld_q;
          s2_idx_q   <= s1_idx_q;
          s2_err_q   <= s1_err_q;
          s2_rdata_q <= s1_rdata;
        end
      end

      assign out_vld   = s2_vld_q;
      assign out_idx   = s2_idx_q;
      assign out_err   = s2_err_q;
      assign out_rdata = s2_rdata_q;
    end else begin : g_lat1
      assign out_vld   = s1_vld_q;
      assign out_idx   = s1_idx_q;
      assign out_err   = s1_err_q;
      assign out_rdata = s1_rdata;
    end
  endgenerate

  // Steer the response to its port; outputs stay quiet while rst is high so a
  // response due in the reset cycle is dropped along with the rest of the pipe.
  always_comb begin
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = '0;
    if (!rst && out_vld) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (out_idx == PW'(p)) begin
          rvalid_d[p] = 1'b1;
          err_d[p]    = out_err;
        end
      end
      rdata_d = out_rdata;
    end
  end

  assign bus.gnt    = gnt_d;
  assign bus.rvalid = rvalid_d;
  assign bus.err    = err_d;
  assign bus.rdata  = rdata_d;

endmodule

// File: tb/tb_code_ram_mp.sv
// Bench for code_ram_mp: round-robin/2-cycle and fixed-priority/1-cycle instances.
// Grants are checked in the request cycle, responses via per-instance scoreboards.
module tb_code_ram_mp;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   rr_last = 2;
  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] sh [2][DEPTH];

  code_ram_mp_if #(.NUM_PORTS(3)) ifa ();
  code_ram_mp_if #(.NUM_PORTS(3)) ifb ();

  code_ram_mp #(
    .NUM_PORTS(3), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .ARB_MODE(1), .READ_LATENCY(2)
  ) u_rr (
    .clk(clk), .rst(rst_a), .bus(ifa)
  );

  code_ram_mp #(
    .NUM_PORTS(3), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .ARB_MODE(0), .READ_LATENCY(1)
  ) u_fp (
    .clk(clk), .rst(rst_b), .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one instance's response outputs against the head of its queue.
  task automatic chk_resp(input string tag, input logic [2:0] rv, input logic [2:0] er,
                          input logic [31:0] rd, ref exp_t q[$]);
    exp_t e;
    logic [2:0] erv;
    logic [2:0] eer;
    n_tests++;
    if (q.size() != 0 && q[0].due <= cyc) begin
      e   = q.pop_front();
      erv = 3'(1 << e.port);
      eer = e.err ? erv : 3'b000;
      assert (rv === erv && er === eer && rd === e.rdata && e.due == cyc) else begin
        n_fail++;
        $error("FAIL %s resp: rvalid=%b err=%b rdata=%h cyc=%0d, expected rvalid=%b err=%b rdata=%h cyc=%0d",
               tag, rv, er, rd, cyc, erv, eer, e.rdata, e.due);
      end
    end else begin
      assert (rv === 3'b000 && er === 3'b000) else begin
        n_fail++;
        $error("FAIL %s idle: rvalid=%b err=%b, expected rvalid=000 err=000 (cyc=%0d)", tag, rv, er, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    chk_resp("rr", ifa.rvalid, ifa.err, ifa.rdata, qa);
    chk_resp("fp", ifb.rvalid, ifb.err, ifb.rdata, qb);
  end

  // Expected winner: d=0 round-robin from rr_last, d=1 lowest index.
  function automatic int pick(input int d, input logic [2:0] r);
    int c;
    int w;
    w = -1;
    if (d == 1) begin
      for (int i = 2; i >= 0; i--) if (r[i]) w = i;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        c = (rr_last + k) % 3;
        if (w < 0 && r[c]) w = c;
      end
    end
    return w;
  endfunction

  // Drive one cycle on instance d, check gnt, record the expected response.
  task automatic step(input int d, input string tag, input logic [2:0] r, input logic [2:0] w,
                      input logic [11:0] b, input logic [95:0] a, input logic [95:0] wd);
    int          p;
    int          widx;
    logic [2:0]  g;
    logic [2:0]  eg;
    logic [31:0] ad;
    logic [31:0] dat;
    logic [3:0]  bb;
    logic        inr;
    exp_t        e;
    if (d == 0) begin
      ifa.req = r; ifa.we = w; ifa.be = b; ifa.addr = a; ifa.wdata = wd;
    end else begin
      ifb.req = r; ifb.we = w; ifb.be = b; ifb.addr = a; ifb.wdata = wd;
    end
    @(negedge clk);
    p  = pick(d, r);
    g  = (d == 0) ? ifa.gnt : ifb.gnt;
    eg = (p < 0) ? 3'b000 : 3'(1 << p);
    n_tests++;
    assert (g === eg) else begin
      n_fail++;
      $error("FAIL %s gnt: got %b, expected %b", tag, g, eg);
    end
    if (p >= 0) begin
      ad   = a[32*p +: 32];
      dat  = wd[32*p +: 32];
      bb   = b[4*p +: 4];
      inr  = (ad >= BASE) && (ad < BASE + 32'(DEPTH * 4));
      widx = inr ? int'((ad - BASE) >> 2) : 0;
      e.port  = p;
      e.err   = !inr;
      e.rdata = (inr && !w[p]) ? sh[d][widx] : 32'h0;
      e.due   = cyc + ((d == 0) ? 2 : 1);
      if (inr && w[p]) begin
        for (int i = 0; i < 4; i++) if (bb[i]) sh[d][widx][8*i +: 8] = dat[8*i +: 8];
      end
      if (d == 0) begin
        qa.push_back(e);
        rr_last = p;
      end else begin
        qb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (d == 0) ifa.req = 3'b000;
    else        ifb.req = 3'b000;
  endtask

  // Single-port access helper.
  task automatic one(input int d, input string tag, input int p, input logic w,
                     input logic [3:0] b, input logic [31:0] ad, input logic [31:0] wd);
    logic [95:0] av;
    logic [95:0] dv;
    logic [11:0] bv;
    av = 96'(ad) << (32 * p);
    dv = 96'(wd) << (32 * p);
    bv = 12'(b) << (4 * p);
    step(d, tag, 3'(1 << p), w ? 3'(1 << p) : 3'b000, bv, av, dv);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.req = 3'b111; ifa.we = 3'b000; ifa.be = '0; ifa.addr = {3{BASE}}; ifa.wdata = '0;
    ifb.req = 3'b111; ifb.we = 3'b000; ifb.be = '0; ifb.addr = {3{BASE}}; ifb.wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    assert (ifa.gnt === 3'b000 && ifa.rvalid === 3'b000 && ifa.err === 3'b000 && ifa.rdata === 32'h0) else begin
      n_fail++;
      $error("FAIL reset_rr: gnt=%b rvalid=%b err=%b rdata=%h, expected all zero", ifa.gnt, ifa.rvalid, ifa.err, ifa.rdata);
    end
    n_tests++;
    assert (ifb.gnt === 3'b000 && ifb.rvalid === 3'b000 && ifb.err === 3'b000 && ifb.rdata === 32'h0) else begin
      n_fail++;
      $error("FAIL reset_fp: gnt=%b rvalid=%b err=%b rdata=%h, expected all zero", ifb.gnt, ifb.rvalid, ifb.err, ifb.rdata);
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.req = 3'b000;
    ifb.req = 3'b000;

    // ---------------- fixed priority, latency 1 ----------------
    one(1, "fp_wr_beef", 0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
    one(1, "fp_rd_beef", 1, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    one(1, "fp_rd_unal", 2, 1'b0, 4'h0, BASE + 32'h13, 32'h0);
    one(1, "fp_wr_m1",   0, 1'b1, 4'hF, BASE + 32'h20, 32'h11223344);
    one(1, "fp_wr_m2",   0, 1'b1, 4'b0101, BASE + 32'h20, 32'hAABBCCDD);
    one(1, "fp_wr_be0",  1, 1'b1, 4'h0, BASE + 32'h20, 32'hFFFFFFFF);
    one(1, "fp_rd_merge",2, 1'b0, 4'h0, BASE + 32'h20, 32'h0);
    for (int i = 0; i < 4; i++)
      step(1, "fp_all3", 3'b111, 3'b000, 12'h0, {3{BASE + 32'h10}}, 96'h0);
    one(1, "fp_wr_w0",   0, 1'b1, 4'hF, BASE,          32'hA5A50001);
    one(1, "fp_wr_wl",   0, 1'b1, 4'hF, BASE + 32'hFC, 32'h5A5A00FF);
    one(1, "fp_oor_rd",  1, 1'b0, 4'h0, BASE + 32'h100, 32'h0);
    one(1, "fp_oor_wr",  2, 1'b1, 4'hF, BASE - 32'h4,  32'hFFFFFFFF);
    one(1, "fp_rd_w0",   0, 1'b0, 4'h0, BASE,          32'h0);
    one(1, "fp_rd_wl",   1, 1'b0, 4'h0, BASE + 32'hFC, 32'h0);
    one(1, "fp_b2b_wr",  0, 1'b1, 4'hF, BASE + 32'h30, 32'hCAFE0123);
    one(1, "fp_b2b_rd",  2, 1'b0, 4'h0, BASE + 32'h30, 32'h0);

    // ---------------- round robin, latency 2 ----------------
    one(0, "rr_wr_beef", 0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
    one(0, "rr_rd_beef", 1, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    for (int i = 0; i < 6; i++)
      step(0, "rr_all3", 3'b111, 3'b000, 12'h0, {3{BASE + 32'h10}}, 96'h0);
    one(0, "rr_b2b_wr",  2, 1'b1, 4'hF, BASE + 32'h50, 32'h600DF00D);
    one(0, "rr_b2b_rd",  0, 1'b0, 4'h0, BASE + 32'h50, 32'h0);
    one(0, "rr_oor_rd",  1, 1'b0, 4'h0, BASE + 32'h200, 32'h0);

    // Two reads in flight, then a one-cycle reset: both responses are dropped.
    repeat (3) @(posedge clk);
    #1;
    one(0, "rr_fl_rd0",  0, 1'b0, 4'h0, BASE + 32'h10, 32'h0);
    one(0, "rr_fl_rd1",  1, 1'b0, 4'h0, BASE + 32'h50, 32'h0);
    rst_a = 1'b1;
    qa.delete();
    rr_last = 2;
    ifa.req = 3'b111; ifa.we = 3'b111; ifa.be = 12'hFFF; ifa.addr = {3{BASE + 32'h10}}; ifa.wdata = '0;
    @(negedge clk);
    n_tests++;
    assert (ifa.gnt === 3'b000 && ifa.rvalid === 3'b000) else begin
      n_fail++;
      $error("FAIL rr_midrst: gnt=%b rvalid=%b, expected gnt=000 rvalid=000", ifa.gnt, ifa.rvalid);
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    ifa.req = 3'b000;
    // Rotation restarts at port 0; the write under reset must not have landed.
    for (int i = 0; i < 6; i++)
      step(0, "rr_post_rst", 3'b111, 3'b000, 12'h0, {3{BASE + 32'h10}}, 96'h0);

    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: pending rr=%0d fp=%0d, expected 0 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
